dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//   Frequency-sweep sequencer for the DDS -> DAC900 output path. Accepts one
//   sweep configuration through a valid/ready handshake. Steps the DDS
//   frequency word K from start to stop in fixed increments, holding each
//   step for a programmable dwell. Drives dds_en, Ken and DAC900_PD.
//   Sits between the control logic and dds/dac900, in the DAC clock domain.
// PARAMETERS
//   FW_W        32   frequency-word width (matches dds K)
//   DWELL_W     24   dwell-counter width
//   SETTLE_CYC  16   cycles between DAC power-up and first dwell (>=1)
// PORTS
//   clk          in   1        DAC-domain clock, rising edge
//   rst_n        in   1        async active-low reset
//   cfg_valid    in   1        config offered
//   cfg_ready    out  1        config accepted when cfg_valid&cfg_ready
//   cfg_start_k  in   FW_W     first frequency word
//   cfg_stop_k   in   FW_W     last allowed frequency word (inclusive)
//   cfg_step_k   in   FW_W     increment per step
//   cfg_dwell    in   DWELL_W  each step held cfg_dwell+1 cycles
//   cfg_repeat   in   1        0 = single sweep, 1 = restart at start forever
//   abort        in   1        stop sweep, power down DAC
//   K            out  FW_W     frequency word to dds
//   Ken          out  1        1-cycle strobe, high in the cycle K takes a new value
//   dds_en       out  1        dds run enable
//   dac_pd       out  1        DAC900_PD, 1 = powered down
//   busy         out  1        high in any state except IDLE
//   done         out  1        1-cycle pulse at end of single sweep
//   cfg_err      out  1        1-cycle pulse on rejected config
// BEHAVIOUR
//   Reset values: state=IDLE, K=0, Ken=0, dds_en=0, dac_pd=1, cfg_ready=1,
//     busy=0, done=0, cfg_err=0. All outputs are registered.
//   States: IDLE, SETTLE, DWELL, DONE. cfg_ready = (state==IDLE).
//   IDLE, on handshake:
//     - Reject if step==0 or start>stop: cfg_err=1 for one cycle, stay IDLE,
//       K unchanged.
//     - Otherwise latch all cfg fields and go to SETTLE. In the next cycle:
//       K=start, Ken=1, dds_en=1, dac_pd=0, busy=1, cnt=SETTLE_CYC-1.
//   SETTLE: cnt decrements; at cnt==0 go to DWELL with cnt=dwell.
//   DWELL: cnt decrements; at cnt==0 compute nxt=K+step in FW_W+1 bits.
//     - nxt<=stop: K=nxt, Ken=1, cnt=dwell, stay in DWELL.
//     - nxt>stop, repeat=1: K=start, Ken=1, cnt=dwell, stay in DWELL.
//     - nxt>stop, repeat=0: go to DONE.
//     - Carry out of FW_W bits always counts as nxt>stop; K never wraps.
//   DONE (one cycle): done=1, dds_en=0, dac_pd=1, then go to IDLE.
//     K keeps its last value.
//   abort in SETTLE/DWELL/DONE: next cycle state=IDLE, dds_en=0, dac_pd=1,
//     Ken=0, done=0, K held. abort has priority over every other transition.
//     abort in IDLE has no effect. abort and cfg_valid together in IDLE:
//     config is accepted.
//   cfg_valid while busy: not accepted; the config must stay offered.
//   Edge cases: start==stop gives one step, held dwell+1 cycles. dwell==0
//     gives a new K every cycle, with Ken high continuously.
//   rst_n low at any point (including mid-sweep) forces the reset values
//     immediately.
// TESTING
//   1 start=100 stop=400 step=100 dwell=3 repeat=0 -> K=100,200,300,400,
//     each held 4 cycles after 16 settle cycles; done pulse; dac_pd back to 1.
//   2 start=0 stop=250 step=100 -> K=0,100,200, then done (300 is never issued).
//   3 start=FFFFFF00 stop=FFFFFFFF step=80 -> K=FFFFFF00, FFFFFF80, then done;
//     no wrap to 0.
//   4 step=0, or start=500 stop=100 -> cfg_err pulse, busy stays 0, dac_pd stays 1.
//   5 repeat=1 start=10 stop=30 step=10 dwell=0 -> K cycles 10,20,30,10,... with
//     Ken high every cycle; abort -> IDLE next cycle, dac_pd=1, no done pulse.
//   6 rst_n low mid-DWELL -> all outputs at reset values at once; a new config
//     is accepted after reset is released.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//   Frequency-sweep sequencer for the DDS -> DAC900 output path, DAC domain.
//   Takes one sweep configuration over a valid/ready handshake, then powers
//   the DAC up, waits SETTLE_CYC cycles and steps the DDS frequency word K
//   from start to stop (inclusive) by step, holding each word dwell+1 cycles.
//   Single sweeps end with a one-cycle done pulse; repeating sweeps restart
//   at start until abort.
//
// Ports
//   clk          DAC-domain clock, rising edge
//   rst_n        asynchronous active-low reset
//   cfg_valid    configuration offered
//   cfg_ready    configuration accepted on cfg_valid & cfg_ready (IDLE only)
//   cfg_start_k  first frequency word
//   cfg_stop_k   last allowed frequency word (inclusive)
//   cfg_step_k   increment per step (0 is rejected)
//   cfg_dwell    each word held cfg_dwell+1 cycles
//   cfg_repeat   0 = single sweep, 1 = restart at start forever
//   abort        stop the sweep and power the DAC down
//   K            frequency word to the DDS
//   Ken          one-cycle strobe in the cycle K takes a new value
//   dds_en       DDS run enable
//   dac_pd       DAC900_PD, 1 = powered down
//   busy         high in every state except IDLE
//   done         one-cycle pulse at the end of a single sweep
//   cfg_err      one-cycle pulse on a rejected configuration
// All outputs are registered.
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int FW_W       = 32,
    parameter int DWELL_W    = 24,
    parameter int SETTLE_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FW_W-1:0]    cfg_start_k,
    input  logic [FW_W-1:0]    cfg_stop_k,
    input  logic [FW_W-1:0]    cfg_step_k,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_repeat,
    input  logic               abort,
    output logic [FW_W-1:0]    K,
    output logic               Ken,
    output logic               dds_en,
    output logic               dac_pd,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DWELL  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // One counter serves both the settle wait and the dwell hold.
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;

    logic [1:0]         state_r,   state_s;
    logic [CNT_W-1:0]   cnt_r,     cnt_s;
    logic [FW_W-1:0]    k_r,       k_s;
    logic               ken_r,     ken_s;
    logic               dds_en_r,  dds_en_s;
    logic               dac_pd_r,  dac_pd_s;
    logic               busy_r,    busy_s;
    logic               done_r,    done_s;
    logic               cfg_err_r, cfg_err_s;
    logic               ready_r,   ready_s;
    logic               latch_s;

    logic [FW_W-1:0]    start_r;
    logic [FW_W-1:0]    stop_r;
    logic [FW_W-1:0]    step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               repeat_r;

    // Next word is formed one bit wider so a carry out of FW_W counts as
    // "past stop" and K can never wrap around to a small value.
    logic [FW_W:0]      nxt_s;
    logic               over_s;
    logic               cnt_zero_s;

    assign nxt_s      = {1'b0, k_r} + {1'b0, step_r};
    assign over_s     = (nxt_s > {1'b0, stop_r});
    assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

    // Next-state and next-output computation for the sweep sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        k_s       = k_r;
        ken_s     = 1'b0;
        dds_en_s  = dds_en_r;
        dac_pd_s  = dac_pd_r;
        done_s    = 1'b0;
        cfg_err_s = 1'b0;
        latch_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // abort is ignored here; a simultaneous config is still taken.
                if (cfg_valid) begin
                    if ((cfg_step_k == {FW_W{1'b0}}) || (cfg_start_k > cfg_stop_k)) begin
                        cfg_err_s = 1'b1;
                    end else begin
                        latch_s  = 1'b1;
                        state_s  = ST_SETTLE;
                        k_s      = cfg_start_k;
                        ken_s    = 1'b1;
                        dds_en_s = 1'b1;
                        dac_pd_s = 1'b0;
                        cnt_s    = CNT_W'(SETTLE_CYC - 1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_s  = ST_IDLE;
                    dds_en_s = 1'b0;
                    dac_pd_s = 1'b1;
                end else if (cnt_zero_s) begin
                    state_s = ST_DWELL;
                    cnt_s   = CNT_W'(dwell_r);
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_s  = ST_IDLE;
                    dds_en_s = 1'b0;
                    dac_pd_s = 1'b1;
                end else if (cnt_zero_s) begin
                    if (!over_s) begin
                        k_s   = nxt_s[FW_W-1:0];
                        ken_s = 1'b1;
                        cnt_s = CNT_W'(dwell_r);
                    end else if (repeat_r) begin
                        k_s   = start_r;
                        ken_s = 1'b1;
                        cnt_s = CNT_W'(dwell_r);
                    end else begin
                        state_s  = ST_DONE;
                        done_s   = 1'b1;
                        dds_en_s = 1'b0;
                        dac_pd_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Abort or not, DONE always returns to IDLE without a pulse.
                state_s  = ST_IDLE;
                dds_en_s = 1'b0;
                dac_pd_s = 1'b1;
            end
            default: begin
                state_s  = ST_IDLE;
                dds_en_s = 1'b0;
                dac_pd_s = 1'b1;
            end
        endcase

        busy_s  = (state_s != ST_IDLE);
        ready_s = (state_s == ST_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            k_r       <= {FW_W{1'b0}};
            ken_r     <= 1'b0;
            dds_en_r  <= 1'b0;
            dac_pd_r  <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            k_r       <= k_s;
            ken_r     <= ken_s;
            dds_en_r  <= dds_en_s;
            dac_pd_r  <= dac_pd_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            cfg_err_r <= cfg_err_s;
            ready_r   <= ready_s;
        end
    end

    // Captured sweep configuration, loaded on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r  <= {FW_W{1'b0}};
            stop_r   <= {FW_W{1'b0}};
            step_r   <= {FW_W{1'b0}};
            dwell_r  <= {DWELL_W{1'b0}};
            repeat_r <= 1'b0;
        end else if (latch_s) begin
            start_r  <= cfg_start_k;
            stop_r   <= cfg_stop_k;
            step_r   <= cfg_step_k;
            dwell_r  <= cfg_dwell;
            repeat_r <= cfg_repeat;
        end
    end

    assign cfg_ready = ready_r;
    assign K         = k_r;
    assign Ken       = ken_r;
    assign dds_en    = dds_en_r;
    assign dac_pd    = dac_pd_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Directed bench for dds_sweep_ctrl: single sweeps, stop-exclusive step,
//   carry-without-wrap, rejected configs, repeat with abort, and asynchronous
//   reset mid-sweep. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    localparam int FW_W   = 32;
    localparam int DW_W   = 24;
    localparam int SETTLE = 16;

    logic            clk;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [FW_W-1:0] cfg_start_k;
    logic [FW_W-1:0] cfg_stop_k;
    logic [FW_W-1:0] cfg_step_k;
    logic [DW_W-1:0] cfg_dwell;
    logic            cfg_repeat;
    logic            abort;
    logic [FW_W-1:0] K;
    logic            Ken;
    logic            dds_en;
    logic            dac_pd;
    logic            busy;
    logic            done;
    logic            cfg_err;

    int tests_run;
    int tests_failed;

    dds_sweep_ctrl #(.FW_W(FW_W), .DWELL_W(DW_W), .SETTLE_CYC(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_start_k (cfg_start_k),
        .cfg_stop_k  (cfg_stop_k),
        .cfg_step_k  (cfg_step_k),
        .cfg_dwell   (cfg_dwell),
        .cfg_repeat  (cfg_repeat),
        .abort       (abort),
        .K           (K),
        .Ken         (Ken),
        .dds_en      (dds_en),
        .dac_pd      (dac_pd),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Offer a config for one rising edge; returns on the following falling edge.
    task automatic cfg_send(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] stp,
                            input logic [23:0] dw, input logic rpt, input logic ab);
        cfg_start_k = st;
        cfg_stop_k  = sp;
        cfg_step_k  = stp;
        cfg_dwell   = dw;
        cfg_repeat  = rpt;
        abort       = ab;
        cfg_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid   = 1'b0;
        abort       = 1'b0;
    endtask

    // Follow an accepted single sweep of nsteps words from the first settle
    // cycle through DONE and back to IDLE.
    task automatic sweep_expect(input string tag, input logic [31:0] st, input logic [31:0] stp,
                                input int nsteps, input int dw);
        int total;
        logic [31:0] kexp;
        logic kenexp;
        total = SETTLE + nsteps * (dw + 1);
        for (int i = 0; i < total; i++) begin
            if (i < SETTLE) kexp = st;
            else            kexp = st + stp * 32'((i - SETTLE) / (dw + 1));
            kenexp = (i == 0) || ((i > SETTLE) && (((i - SETTLE) % (dw + 1)) == 0));
            check({tag, "_K"},    64'(K),    64'(kexp));
            check({tag, "_Ken"},  64'(Ken),  64'(kenexp));
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_pd"},   64'(dac_pd), 64'd0);
            @(negedge clk);
        end
        kexp = st + stp * 32'(nsteps - 1);
        check({tag, "_done"},      64'(done),   64'd1);
        check({tag, "_done_pd"},   64'(dac_pd), 64'd1);
        check({tag, "_done_en"},   64'(dds_en), 64'd0);
        check({tag, "_done_busy"}, 64'(busy),   64'd1);
        check({tag, "_done_K"},    64'(K),      64'(kexp));
        @(negedge clk);
        check({tag, "_idle_done"},  64'(done),      64'd0);
        check({tag, "_idle_busy"},  64'(busy),      64'd0);
        check({tag, "_idle_ready"}, 64'(cfg_ready), 64'd1);
        check({tag, "_idle_K"},     64'(K),         64'(kexp));
    endtask

    initial begin
        logic [31:0] rep_vals [3];
        tests_run    = 0;
        tests_failed = 0;
        rep_vals[0] = 32'd10;
        rep_vals[1] = 32'd20;
        rep_vals[2] = 32'd30;
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_start_k = 32'd0;
        cfg_stop_k  = 32'd0;
        cfg_step_k  = 32'd0;
        cfg_dwell   = 24'd0;
        cfg_repeat  = 1'b0;
        abort       = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_K",     64'(K),         64'd0);
        check("rst_Ken",   64'(Ken),       64'd0);
        check("rst_en",    64'(dds_en),    64'd0);
        check("rst_pd",    64'(dac_pd),    64'd1);
        check("rst_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_err",   64'(cfg_err),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: four steps, dwell 3.
        cfg_send(32'd100, 32'd400, 32'd100, 24'd3, 1'b0, 1'b0);
        check("t1_ready", 64'(cfg_ready), 64'd0);
        check("t1_en",    64'(dds_en),    64'd1);
        sweep_expect("t1", 32'd100, 32'd100, 4, 3);

        // 2: 300 would exceed stop, so only three words.
        cfg_send(32'd0, 32'd250, 32'd100, 24'd1, 1'b0, 1'b0);
        sweep_expect("t2", 32'd0, 32'd100, 3, 1);

        // 3: next word carries out of 32 bits and must end the sweep.
        cfg_send(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd0, 1'b0, 1'b0);
        sweep_expect("t3", 32'hFFFF_FF00, 32'h80, 2, 0);

        // 4: rejected configs leave K and power state alone.
        cfg_send(32'd5, 32'd50, 32'd0, 24'd1, 1'b0, 1'b0);
        check("t4a_err",  64'(cfg_err), 64'd1);
        check("t4a_busy", 64'(busy),    64'd0);
        check("t4a_pd",   64'(dac_pd),  64'd1);
        check("t4a_K",    64'(K),       64'hFFFF_FF80);
        @(negedge clk);
        check("t4a_err_clr", 64'(cfg_err), 64'd0);
        cfg_send(32'd500, 32'd100, 32'd10, 24'd1, 1'b0, 1'b0);
        check("t4b_err",   64'(cfg_err),   64'd1);
        check("t4b_busy",  64'(busy),      64'd0);
        check("t4b_pd",    64'(dac_pd),    64'd1);
        check("t4b_ready", 64'(cfg_ready), 64'd1);
        @(negedge clk);
        check("t4b_err_clr", 64'(cfg_err), 64'd0);

        // 5: repeat with dwell 0, then abort.
        cfg_send(32'd10, 32'd30, 32'd10, 24'd0, 1'b1, 1'b0);
        repeat (SETTLE) @(negedge clk);
        for (int i = SETTLE; i < SETTLE + 9; i++) begin
            check("t5_K", 64'(K), 64'(rep_vals[(i - SETTLE) % 3]));
            check("t5_Ken", 64'(Ken), (i == SETTLE) ? 64'd0 : 64'd1);
            if (i == SETTLE + 8) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        check("t5_ab_busy", 64'(busy),   64'd0);
        check("t5_ab_pd",   64'(dac_pd), 64'd1);
        check("t5_ab_en",   64'(dds_en), 64'd0);
        check("t5_ab_Ken",  64'(Ken),    64'd0);
        check("t5_ab_done", 64'(done),   64'd0);
        check("t5_ab_K",    64'(K),      64'(rep_vals[2]));
        @(negedge clk);
        check("t5_ab_done2", 64'(done), 64'd0);

        // 6: config with abort in IDLE is accepted; reset mid-dwell.
        cfg_send(32'd100, 32'd400, 32'd100, 24'd3, 1'b0, 1'b1);
        check("t6_acc_busy", 64'(busy), 64'd1);
        check("t6_acc_K",    64'(K),    64'd100);
        repeat (SETTLE + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_K",     64'(K),         64'd0);
        check("t6_rst_Ken",   64'(Ken),       64'd0);
        check("t6_rst_en",    64'(dds_en),    64'd0);
        check("t6_rst_pd",    64'(dac_pd),    64'd1);
        check("t6_rst_ready", 64'(cfg_ready), 64'd1);
        check("t6_rst_busy",  64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // start == stop: exactly one word, held dwell+1 cycles.
        cfg_send(32'd5, 32'd5, 32'd1, 24'd2, 1'b0, 1'b0);
        sweep_expect("t6", 32'd5, 32'd1, 1, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
